// File: rtl/alu_reservation_station.sv
// ALU reservation station.
// Holds ALU commands until both operands are known, snoops the CDB to pick
// up pending operands, hands ready commands to the ALU over a valid/ready
// handshake, and keeps each entry's result tag reserved until the CDB
// broadcasts that result.
module alu_reservation_station #(
  parameter int DATA_WIDTH    = 4,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int ENTRIES       = 4,
  parameter int OP_WIDTH      = 3,
  parameter int TAG_BASE      = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_in_data,
  input  logic                     command_update_en,
  input  logic [OP_WIDTH-1:0]      command_op,
  input  logic [DATA_WIDTH-1:0]    operand_a_data,
  input  logic                     operand_a_data_is_valid,
  input  logic [DATA_WIDTH-1:0]    operand_b_data,
  input  logic                     operand_b_data_is_valid,
  output logic                     command_update_accepted,
  output logic [CDB_TAG_WIDTH-1:0] command_result_cdb_tag,
  output logic                     issue_valid,
  output logic [OP_WIDTH-1:0]      issue_op,
  output logic [DATA_WIDTH-1:0]    issue_a,
  output logic [DATA_WIDTH-1:0]    issue_b,
  output logic [CDB_TAG_WIDTH-1:0] issue_tag,
  input  logic                     issue_ready,
  output logic                     full
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_READY   = 2'd2,
    ST_ISSUED  = 2'd3
  } state_e;

  // Operand fields hold the value once resolved; while pending, their low
  // CDB_TAG_WIDTH bits hold the producer tag being waited on.
  state_e                  state_q [ENTRIES];
  state_e                  state_d [ENTRIES];
  logic [OP_WIDTH-1:0]     op_q    [ENTRIES];
  logic [OP_WIDTH-1:0]     op_d    [ENTRIES];
  logic [DATA_WIDTH-1:0]   a_q     [ENTRIES];
  logic [DATA_WIDTH-1:0]   a_d     [ENTRIES];
  logic [DATA_WIDTH-1:0]   b_q     [ENTRIES];
  logic [DATA_WIDTH-1:0]   b_d     [ENTRIES];
  logic                    a_rdy_q [ENTRIES];
  logic                    a_rdy_d [ENTRIES];
  logic                    b_rdy_q [ENTRIES];
  logic                    b_rdy_d [ENTRIES];

  logic                    cdb_hit;
  logic                    free_found;
  logic [IDX_W-1:0]        alloc_idx;
  logic [IDX_W-1:0]        issue_idx;
  logic                    issue_fire;

  function automatic logic [CDB_TAG_WIDTH-1:0] entry_tag(input int idx);
    return CDB_TAG_WIDTH'(TAG_BASE + idx);
  endfunction

  // Tag 0 is never allocated, so a broadcast of it is treated as no broadcast.
  assign cdb_hit = cdb_in_valid && (cdb_in_tag != '0);

  // Lowest-index FREE entry, taken from registered state only, so an entry
  // retiring this cycle is not reused until the next one.
  always_comb begin
    free_found             = 1'b0;
    alloc_idx              = '0;
    command_result_cdb_tag = entry_tag(0);
    for (int i = 0; i < ENTRIES; i++) begin
      if (!free_found && state_q[i] == ST_FREE) begin
        free_found             = 1'b1;
        alloc_idx              = IDX_W'(i);
        command_result_cdb_tag = entry_tag(i);
      end
    end
  end

  assign full                    = !free_found;
  assign command_update_accepted = command_update_en && !full;

  // Lowest-index READY entry drives the issue port; zeros when none is ready.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    issue_op    = '0;
    issue_a     = '0;
    issue_b     = '0;
    issue_tag   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!issue_valid && state_q[i] == ST_READY) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(i);
        issue_op    = op_q[i];
        issue_a     = a_q[i];
        issue_b     = b_q[i];
        issue_tag   = entry_tag(i);
      end
    end
  end

  assign issue_fire = issue_valid && issue_ready;

  // Per-entry next state: allocation with same-cycle CDB forward, operand
  // snoop, issue handshake and retire on the entry's own tag.
  always_comb begin
    logic a_ok;
    logic b_ok;
    logic [DATA_WIDTH-1:0] a_val;
    logic [DATA_WIDTH-1:0] b_val;
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      a_d[i]     = a_q[i];
      b_d[i]     = b_q[i];
      a_rdy_d[i] = a_rdy_q[i];
      b_rdy_d[i] = b_rdy_q[i];
      a_ok       = 1'b0;
      b_ok       = 1'b0;
      a_val      = '0;
      b_val      = '0;
      case (state_q[i])
        ST_FREE: begin
          if (command_update_accepted && alloc_idx == IDX_W'(i)) begin
            a_ok  = operand_a_data_is_valid;
            a_val = operand_a_data;
            if (!operand_a_data_is_valid && cdb_hit &&
                cdb_in_tag == operand_a_data[CDB_TAG_WIDTH-1:0]) begin
              a_ok  = 1'b1;
              a_val = cdb_in_data;
            end
            b_ok  = operand_b_data_is_valid;
            b_val = operand_b_data;
            if (!operand_b_data_is_valid && cdb_hit &&
                cdb_in_tag == operand_b_data[CDB_TAG_WIDTH-1:0]) begin
              b_ok  = 1'b1;
              b_val = cdb_in_data;
            end
            op_d[i]    = command_op;
            a_d[i]     = a_val;
            b_d[i]     = b_val;
            a_rdy_d[i] = a_ok;
            b_rdy_d[i] = b_ok;
            state_d[i] = (a_ok && b_ok) ? ST_READY : ST_WAITING;
          end
        end
        ST_WAITING: begin
          a_ok = a_rdy_q[i];
          b_ok = b_rdy_q[i];
          if (!a_rdy_q[i] && cdb_hit && cdb_in_tag == a_q[i][CDB_TAG_WIDTH-1:0]) begin
            a_ok   = 1'b1;
            a_d[i] = cdb_in_data;
          end
          if (!b_rdy_q[i] && cdb_hit && cdb_in_tag == b_q[i][CDB_TAG_WIDTH-1:0]) begin
            b_ok   = 1'b1;
            b_d[i] = cdb_in_data;
          end
          a_rdy_d[i] = a_ok;
          b_rdy_d[i] = b_ok;
          if (a_ok && b_ok) begin
            state_d[i] = ST_READY;
          end
        end
        ST_READY: begin
          if (issue_fire && issue_idx == IDX_W'(i)) begin
            state_d[i] = ST_ISSUED;
          end
        end
        ST_ISSUED: begin
          if (cdb_hit && cdb_in_tag == entry_tag(i)) begin
            state_d[i] = ST_FREE;
          end
        end
        default: state_d[i] = ST_FREE;
      endcase
    end
  end

  // Entry registers; reset discards every entry, including in-flight ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (!rst_n) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        a_rdy_q[i] <= 1'b0;
        b_rdy_q[i] <= 1'b0;
      end else begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        a_q[i]     <= a_d[i];
        b_q[i]     <= b_d[i];
        a_rdy_q[i] <= a_rdy_d[i];
        b_rdy_q[i] <= b_rdy_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random
// traffic, checked against a per-tag reference model through a scoreboard.
module tb_alu_reservation_station;

  localparam int DW = 4;
  localparam int TW = 4;
  localparam int N  = 4;
  localparam int OW = 3;
  localparam int TB = 1;

  logic          clk;
  logic          rst_n;
  logic          cdb_in_valid;
  logic [TW-1:0] cdb_in_tag;
  logic [DW-1:0] cdb_in_data;
  logic          command_update_en;
  logic [OW-1:0] command_op;
  logic [DW-1:0] operand_a_data;
  logic          operand_a_data_is_valid;
  logic [DW-1:0] operand_b_data;
  logic          operand_b_data_is_valid;
  logic          command_update_accepted;
  logic [TW-1:0] command_result_cdb_tag;
  logic          issue_valid;
  logic [OW-1:0] issue_op;
  logic [DW-1:0] issue_a;
  logic [DW-1:0] issue_b;
  logic [TW-1:0] issue_tag;
  logic          issue_ready;
  logic          full;

  alu_reservation_station #(
    .DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .ENTRIES(N), .OP_WIDTH(OW), .TAG_BASE(TB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cdb_in_valid(cdb_in_valid), .cdb_in_tag(cdb_in_tag), .cdb_in_data(cdb_in_data),
    .command_update_en(command_update_en), .command_op(command_op),
    .operand_a_data(operand_a_data), .operand_a_data_is_valid(operand_a_data_is_valid),
    .operand_b_data(operand_b_data), .operand_b_data_is_valid(operand_b_data_is_valid),
    .command_update_accepted(command_update_accepted),
    .command_result_cdb_tag(command_result_cdb_tag),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a),
    .issue_b(issue_b), .issue_tag(issue_tag), .issue_ready(issue_ready), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          full;
    bit          acc;
    logic [TW-1:0] tag;
    bit          iv;
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] itag;
    bit          zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per result tag (slot k owns tag TB+k).
  bit            m_busy [N];
  bit            m_iss  [N];
  bit            m_ak   [N];
  bit            m_bk   [N];
  logic [OW-1:0] m_op   [N];
  logic [DW-1:0] m_a    [N];
  logic [DW-1:0] m_b    [N];
  logic [TW-1:0] m_at   [N];
  logic [TW-1:0] m_bt   [N];
  bit            after_reset = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("full", 32'(full), 32'(e.full));
        chk("accepted", 32'(command_update_accepted), 32'(e.acc));
        if (!e.full) chk("alloc_tag", 32'(command_result_cdb_tag), 32'(e.tag));
        chk("issue_valid", 32'(issue_valid), 32'(e.iv));
        if (e.iv) begin
          chk("issue_op", 32'(issue_op), 32'(e.op));
          chk("issue_a", 32'(issue_a), 32'(e.a));
          chk("issue_b", 32'(issue_b), 32'(e.b));
          chk("issue_tag", 32'(issue_tag), 32'(e.itag));
        end
        if (e.zero) begin
          chk("reset_issue_fields", {issue_op, issue_a, issue_b, issue_tag}, 32'd0);
        end
      end
    end
  end

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit rst, input bit en, input logic [OW-1:0] op,
                      input logic [DW-1:0] ad, input bit av,
                      input logic [DW-1:0] bd, input bit bv,
                      input bit cv, input logic [TW-1:0] ct, input logic [DW-1:0] cd,
                      input bit rdy);
    exp_t e;
    int   fs;
    int   rs;
    bit   hit;
    @(posedge clk);
    #1;
    rst_n                   = rst;
    command_update_en       = en;
    command_op              = op;
    operand_a_data          = ad;
    operand_a_data_is_valid = av;
    operand_b_data          = bd;
    operand_b_data_is_valid = bv;
    cdb_in_valid            = cv;
    cdb_in_tag              = ct;
    cdb_in_data             = cd;
    issue_ready             = rdy;

    fs = -1;
    rs = -1;
    for (int k = 0; k < N; k++) begin
      if (fs < 0 && !m_busy[k]) fs = k;
      if (rs < 0 && m_busy[k] && !m_iss[k] && m_ak[k] && m_bk[k]) rs = k;
    end
    e.full = (fs < 0);
    e.acc  = en && (fs >= 0);
    e.tag  = (fs >= 0) ? TW'(TB + fs) : '0;
    e.iv   = (rs >= 0);
    e.op   = (rs >= 0) ? m_op[rs] : '0;
    e.a    = (rs >= 0) ? m_a[rs] : '0;
    e.b    = (rs >= 0) ? m_b[rs] : '0;
    e.itag = (rs >= 0) ? TW'(TB + rs) : '0;
    e.zero = after_reset;
    exp_q.push_back(e);

    hit = cv && (ct != '0);
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        m_busy[k] = 1'b0;
        m_iss[k]  = 1'b0;
      end
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_busy[k] && m_iss[k] && hit && ct == TW'(TB + k)) begin
          m_busy[k] = 1'b0;
        end else if (m_busy[k] && !m_iss[k]) begin
          if (!m_ak[k] && hit && ct == m_at[k]) begin m_ak[k] = 1'b1; m_a[k] = cd; end
          if (!m_bk[k] && hit && ct == m_bt[k]) begin m_bk[k] = 1'b1; m_b[k] = cd; end
        end
      end
      if (rs >= 0 && rdy) m_iss[rs] = 1'b1;
      if (e.acc) begin
        m_busy[fs] = 1'b1;
        m_iss[fs]  = 1'b0;
        m_op[fs]   = op;
        m_at[fs]   = ad[TW-1:0];
        m_bt[fs]   = bd[TW-1:0];
        m_ak[fs]   = av || (hit && ct == ad[TW-1:0]);
        m_bk[fs]   = bv || (hit && ct == bd[TW-1:0]);
        m_a[fs]    = av ? ad : cd;
        m_b[fs]    = bv ? bd : cd;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(1, 0, '0, '0, 0, '0, 0, 0, '0, '0, rdy);
  endtask

  task automatic bcast(input logic [TW-1:0] t, input logic [DW-1:0] d, input bit rdy);
    step(1, 0, '0, '0, 0, '0, 0, 1, t, d, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    command_update_en = 1'b0; command_op = '0;
    operand_a_data = '0; operand_a_data_is_valid = 1'b0;
    operand_b_data = '0; operand_b_data_is_valid = 1'b0;
    cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
    issue_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 1'b0; m_iss[k] = 1'b0; m_ak[k] = 1'b0; m_bk[k] = 1'b0;
      m_op[k] = '0; m_a[k] = '0; m_b[k] = '0; m_at[k] = '0; m_bt[k] = '0;
    end
    repeat (2) @(posedge clk);

    // Basic accept, issue, retire.
    step(1, 1, 3'd2, 4'd3, 1, 4'd5, 1, 0, '0, '0, 0);
    idle(1);
    bcast(4'd1, 4'd0, 0);
    idle(0);

    // Operand A pending on an external tag, woken by the CDB.
    step(1, 1, 3'd1, 4'd7, 0, 4'd4, 1, 0, '0, '0, 0);
    idle(0);
    bcast(4'd7, 4'd9, 0);
    idle(1);
    bcast(4'd1, 4'd0, 0);

    // Same-cycle forward at allocation.
    step(1, 1, 3'd5, 4'd6, 0, 4'd1, 1, 1, 4'd6, 4'hA, 0);
    idle(1);
    bcast(4'd1, 4'd0, 0);
    idle(0);

    // Fill all entries, reject while full, free one and reuse its tag.
    for (int k = 0; k < N; k++) step(1, 1, OW'(k), DW'(k), 1, DW'(k + 1), 1, 0, '0, '0, 0);
    step(1, 1, 3'd7, 4'd1, 1, 4'd1, 1, 0, '0, '0, 0);
    idle(1);
    step(1, 1, 3'd6, 4'd2, 1, 4'd3, 1, 1, 4'd1, 4'd0, 0);
    step(1, 1, 3'd6, 4'd2, 1, 4'd3, 1, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0, '0, 0, 0, '0, '0, 0);

    // Two entries waiting on the same tag wake together and issue in order.
    step(1, 1, 3'd3, 4'd5, 0, 4'd1, 1, 0, '0, '0, 0);
    step(1, 1, 3'd4, 4'd5, 0, 4'd2, 1, 0, '0, '0, 0);
    bcast(4'd5, 4'd2, 0);
    idle(1);
    idle(1);

    // Reset with entries issued and waiting.
    step(1, 1, 3'd1, 4'd9, 0, 4'd9, 0, 0, '0, '0, 0);
    step(0, 1, 3'd1, 4'd1, 1, 4'd1, 1, 0, '0, '0, 0);
    idle(0);

    // Random traffic, with an occasional reset.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 9) < 6, OW'($urandom),
           DW'($urandom_range(0, 7)), $urandom_range(0, 9) < 6,
           DW'($urandom_range(0, 7)), $urandom_range(0, 9) < 6,
           $urandom_range(0, 1) == 1, TW'($urandom_range(0, 7)), DW'($urandom),
           $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
